// File: rtl/tick_timer_arbiter.sv
// tick_timer_arbiter: shares one prescaled tick timer among NREQ requesters.
// A round-robin winner is granted the timer, the prescaler is realigned with a
// one-cycle clear, and the winner's delay is counted down in ticks before a
// one-cycle done pulse is returned. Dropping the request aborts the run.
module tick_timer_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick_in,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*DW-1:0]   delay,
    output logic                 cnt_clr,
    output logic [NREQ-1:0]      grant,
    output logic [NREQ-1:0]      done,
    output logic                 busy,
    output logic [DW-1:0]        remaining
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [NREQ-1:0] GRANT_ONE = NREQ'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [PW-1:0]   r_ptr;
    logic [NREQ-1:0] r_grant;
    logic [NREQ-1:0] r_done;
    logic            r_cnt_clr;
    logic            r_busy;
    logic [DW-1:0]   r_remaining;

    logic            w_found;
    logic [PW-1:0]   w_winner;
    logic [DW-1:0]   w_delaySel;
    logic            w_tickOk;
    logic            w_reqHeld;

    // Round-robin search starting just after the last winner, wrapping around.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!w_found && req[(int'(r_ptr) + k) % NREQ]) begin
                w_found  = 1'b1;
                w_winner = PW'((int'(r_ptr) + k) % NREQ);
            end
        end
    end

    assign w_delaySel = delay[int'(w_winner) * DW +: DW];
    // The tick arriving alongside the prescaler clear belongs to the old phase.
    assign w_tickOk   = tick_in && !r_cnt_clr;
    assign w_reqHeld  = req[r_ptr];

    // Arbitration / countdown FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ptr       <= PW'(NREQ - 1);
            r_grant     <= '0;
            r_done      <= '0;
            r_cnt_clr   <= 1'b0;
            r_busy      <= 1'b0;
            r_remaining <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done    <= '0;
                    r_cnt_clr <= 1'b0;
                    if (w_found) begin
                        r_state     <= RUN;
                        r_grant     <= GRANT_ONE << w_winner;
                        r_remaining <= w_delaySel;
                        r_cnt_clr   <= 1'b1;
                        r_ptr       <= w_winner;
                        r_busy      <= 1'b1;
                    end
                end
                RUN: begin
                    r_cnt_clr <= 1'b0;
                    if (!w_reqHeld) begin
                        r_state     <= IDLE;
                        r_grant     <= '0;
                        r_busy      <= 1'b0;
                        r_remaining <= '0;
                    end else if (r_remaining == '0) begin
                        r_state <= DONE;
                        r_done  <= r_grant;
                    end else if (w_tickOk) begin
                        r_remaining <= r_remaining - DW'(1);
                    end
                end
                DONE: begin
                    r_state   <= IDLE;
                    r_grant   <= '0;
                    r_done    <= '0;
                    r_busy    <= 1'b0;
                    r_cnt_clr <= 1'b0;
                end
                default: begin
                    r_state   <= IDLE;
                    r_grant   <= '0;
                    r_done    <= '0;
                    r_busy    <= 1'b0;
                    r_cnt_clr <= 1'b0;
                end
            endcase
        end
    end

    assign cnt_clr   = r_cnt_clr;
    assign grant     = r_grant;
    assign done      = r_done;
    assign busy      = r_busy;
    assign remaining = r_remaining;

endmodule
